hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Issue/interlock controller between decode and execute of the ARC MIPS pipeline.
//  Tracks in-flight register writes in a shadow pipeline and stalls decode on RAW hazards.
//  Squashes issue after a taken branch and drives the bubble into the ID/EX register.
//  Sits beside decode; the register bank is read in decode, so hazards are resolved here.
// PARAMETERS
//  PIPE_DEPTH   3  shadow slots tracked after issue (slot0=EX, slot1=MEM, slot2=WB)
//  FLUSH_DEPTH  1  youngest slots invalidated on i_con_Flush (slot0..FLUSH_DEPTH-1)
//  WB_BYPASS    1  1: last slot never hazards (bank writes before read); 0: it does
// PORTS
//  i_clk        in   1  clock, rising edge
//  i_rst        in   1  reset; asynchronous, active-high
//  i_con_DecVal in   1  decode holds a valid instruction
//  i_addr_Rs    in   5  decode source register A
//  i_addr_Rt    in   5  decode source register B
//  i_con_UseRs  in   1  instruction reads Rs
//  i_con_UseRt  in   1  instruction reads Rt
//  i_addr_Dst   in   5  destination (post-RegDst mux)
//  i_con_RegWr  in   1  instruction writes a register
//  i_con_Flush  in   1  taken branch resolved in MEM; squash younger work
//  o_con_Stall  out  1  hold PC and IF/ID registers this cycle
//  o_con_Issue  out  1  decode instruction enters ID/EX this cycle
//  o_con_Bubble out  1  load NOP controls into ID/EX this cycle
//  o_con_State  out  2  FSM state (debug)
// BEHAVIOUR
//  Reset (async): all slots invalid, state RUN; Stall=0, Issue=0, Bubble=1.
//  Slot = {valid, dst[4:0], regwr}. Shift every clock: slot[k+1]<=slot[k]; slot[PIPE_DEPTH-1] retires.
//  Hazard(src) = OR over slots k of valid & regwr & dst==src & src!=0,
//   k in 0..PIPE_DEPTH-2 if WB_BYPASS else 0..PIPE_DEPTH-1.
//  Stall = DecVal & state!=FLUSH & ((UseRs & Hazard(Rs)) | (UseRt & Hazard(Rt))); combinational.
//  Issue = DecVal & !Stall & !i_con_Flush & state!=FLUSH. Bubble = !Issue. Both combinational.
//  slot0 next = Issue ? {1,Dst,RegWr} : {0,0,0}. Dst==0 with RegWr=1: tracked but never matches.
//  FSM: RUN  -> STALL when Stall; -> FLUSH when i_con_Flush.
//       STALL-> RUN when !Stall; -> FLUSH when i_con_Flush (Flush has priority).
//       FLUSH-> RUN unconditionally after 1 cycle (wrong-path IF/ID squashed, Issue=0, Stall=0).
//  Flush edge: slots 0..FLUSH_DEPTH-1 cleared (not shifted in), older slots shift normally.
//  Flush while in FLUSH: stays FLUSH one more cycle.
//  Stall duration bounded by PIPE_DEPTH-1 (WB_BYPASS=1) or PIPE_DEPTH cycles; no deadlock.
//  Reset asserted mid-stall/flush: immediate return to reset values, no pending state kept.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds o_stat_StallCnt[31:0], o_stat_FlushCnt[31:0];
//   +1 per cycle with Stall=1 / per cycle with i_con_Flush=1; saturate at 32'hFFFF_FFFF; reset 0.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  arc_pkg: typedef struct packed {logic valid; logic [4:0] dst; logic regwr;} inflight_t;
//   typedef enum logic [1:0] {HZ_RUN=0, HZ_STALL=1, HZ_FLUSH=2} hz_state_e; REG_ZERO=5'd0.
//  Sub-module inflight_pipe: PIPE_DEPTH shift register of inflight_t with per-slot clear mask
//   and per-slot match vectors for Rs/Rt; hazard_ctrl holds FSM, issue logic, stats.
// TESTING
//  1 add $3 issued, next instr reads $3 (UseRs) -> Stall=1 for 2 cycles, then Issue=1; WB_BYPASS=0 -> 3 cycles.
//  2 instr writes $0 then reader of $0 -> no Stall; Issue=1 back-to-back.
//  3 stall on $5 with i_con_Flush=1 same cycle -> Issue=0, next state FLUSH, slot0 cleared, then RUN.
//  4 independent stream ($1..$8, no overlap) 20 cycles -> Stall never 1, Issue every cycle.
//  5 i_rst pulsed mid-stall -> Stall=0, Bubble=1, State=RUN asynchronously; slots empty after release.
//  6 HAZARD_STATS_EN: scenario 1 then 3 -> StallCnt=3, FlushCnt=1.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared types for the ARC MIPS issue/interlock logic.
// In-flight write record, hazard FSM states and the slot match helper.
package arc_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regwr;
    } inflight_t;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hard-wired, so a pending write to it never blocks a reader.
    function automatic logic slot_hit(inflight_t s, logic [4:0] src);
        return s.valid & s.regwr & (s.dst == src) & (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/inflight_pipe.sv
// Shadow pipeline of register writes issued past decode (slot0=EX onward).
// Each slot can be cleared on the shift edge; match vectors are per slot.
module inflight_pipe
    import arc_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  inflight_t        ins,
    input  logic [DEPTH-1:0] clr,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    output logic [DEPTH-1:0] rs_hit,
    output logic [DEPTH-1:0] rt_hit
);

    inflight_t [DEPTH-1:0] slots;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else begin
            slots[0] <= clr[0] ? '0 : ins;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= clr[k] ? '0 : slots[k-1];
            end
        end
    end

    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rs_hit[k] = slot_hit(slots[k], rs);
            rt_hit[k] = slot_hit(slots[k], rt);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/execute interlock: RAW stall, branch squash and ID/EX bubble.
// Define HAZARD_STATS_EN to add saturating stall/flush cycle counters.
module hazard_ctrl
    import arc_pkg::*;
#(
    parameter int PIPE_DEPTH  = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int WB_BYPASS   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_con_DecVal,
    input  logic [4:0]  i_addr_Rs,
    input  logic [4:0]  i_addr_Rt,
    input  logic        i_con_UseRs,
    input  logic        i_con_UseRt,
    input  logic [4:0]  i_addr_Dst,
    input  logic        i_con_RegWr,
    input  logic        i_con_Flush,
    output logic        o_con_Stall,
    output logic        o_con_Issue,
    output logic        o_con_Bubble,
    output logic [1:0]  o_con_State
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] o_stat_StallCnt,
    output logic [31:0] o_stat_FlushCnt
`endif
);

    // With write-before-read in the bank, the oldest slot is already visible.
    localparam int HZ_SLOTS = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    hz_state_e state, state_nx;

    logic [PIPE_DEPTH-1:0] chk_mask;
    logic [PIPE_DEPTH-1:0] clr_mask;
    logic [PIPE_DEPTH-1:0] rs_hit;
    logic [PIPE_DEPTH-1:0] rt_hit;
    logic                  hz_rs;
    logic                  hz_rt;
    logic                  in_flush;
    logic                  stall;
    logic                  issue;
    inflight_t             ins;

    always_comb begin
        chk_mask = '0;
        clr_mask = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            chk_mask[k] = (k < HZ_SLOTS);
            clr_mask[k] = i_con_Flush & (k < FLUSH_DEPTH);
        end
    end

    always_comb begin
        ins = '0;
        if (issue) begin
            ins.valid = 1'b1;
            ins.dst   = i_addr_Dst;
            ins.regwr = i_con_RegWr;
        end
    end

    inflight_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .clk    (i_clk),
        .rst    (i_rst),
        .ins    (ins),
        .clr    (clr_mask),
        .rs     (i_addr_Rs),
        .rt     (i_addr_Rt),
        .rs_hit (rs_hit),
        .rt_hit (rt_hit)
    );

    assign in_flush = (state == HZ_FLUSH);
    assign hz_rs    = i_con_UseRs & (|(rs_hit & chk_mask));
    assign hz_rt    = i_con_UseRt & (|(rt_hit & chk_mask));

    // Gated by reset so the outputs take their reset values asynchronously.
    assign stall = ~i_rst & i_con_DecVal & ~in_flush & (hz_rs | hz_rt);
    assign issue = ~i_rst & i_con_DecVal & ~stall & ~i_con_Flush & ~in_flush;

    assign o_con_Stall  = stall;
    assign o_con_Issue  = issue;
    assign o_con_Bubble = ~issue;
    assign o_con_State  = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HZ_RUN: begin
                if (i_con_Flush) begin
                    state_nx = HZ_FLUSH;
                end else if (stall) begin
                    state_nx = HZ_STALL;
                end
            end
            HZ_STALL: begin
                if (i_con_Flush) begin
                    state_nx = HZ_FLUSH;
                end else if (!stall) begin
                    state_nx = HZ_RUN;
                end
            end
            HZ_FLUSH: begin
                state_nx = i_con_Flush ? HZ_FLUSH : HZ_RUN;
            end
            default: begin
                state_nx = HZ_RUN;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat_StallCnt <= '0;
            o_stat_FlushCnt <= '0;
        end else begin
            if (stall && (o_stat_StallCnt != 32'hFFFF_FFFF)) begin
                o_stat_StallCnt <= o_stat_StallCnt + 32'd1;
            end
            if (i_con_Flush && (o_stat_FlushCnt != 32'hFFFF_FFFF)) begin
                o_stat_FlushCnt <= o_stat_FlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: queue-based reference model, per-cycle compare,
// directed scenarios plus random traffic. HAZARD_STATS_EN adds counter checks.
module tb_hazard_ctrl;

    localparam int D  = 3;
    localparam int FD = 1;
    localparam int WB = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic       urs = 1'b0;
    logic       urt = 1'b0;
    logic       rw  = 1'b0;
    logic       fl  = 1'b0;
    logic [4:0] rs  = 5'd0;
    logic [4:0] rt  = 5'd0;
    logic [4:0] dst = 5'd0;

    logic       stall;
    logic       issue;
    logic       bubble;
    logic [1:0] state;
`ifdef HAZARD_STATS_EN
    logic [31:0] scnt;
    logic [31:0] fcnt;
`endif

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       w;
    } ent_t;

    ent_t   q[$];
    int     mst = 0;
    longint m_scnt = 0;
    longint m_fcnt = 0;

    logic       s_stall;
    logic       s_issue;
    logic [1:0] s_state;

    hazard_ctrl #(
        .PIPE_DEPTH  (D),
        .FLUSH_DEPTH (FD),
        .WB_BYPASS   (WB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_con_DecVal (dv),
        .i_addr_Rs    (rs),
        .i_addr_Rt    (rt),
        .i_con_UseRs  (urs),
        .i_con_UseRt  (urt),
        .i_addr_Dst   (dst),
        .i_con_RegWr  (rw),
        .i_con_Flush  (fl),
        .o_con_Stall  (stall),
        .o_con_Issue  (issue),
        .o_con_Bubble (bubble),
        .o_con_State  (state)
`ifdef HAZARD_STATS_EN
        ,
        .o_stat_StallCnt (scnt),
        .o_stat_FlushCnt (fcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // q[0] is the most recently issued instruction (EX).
    function automatic bit haz(input logic [4:0] src);
        int lim;
        lim = (WB != 0) ? D - 1 : D;
        for (int k = 0; k < lim && k < q.size(); k++) begin
            if (q[k].v && q[k].w && q[k].d == src && src != 5'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit e_stall();
        return !rst && dv && mst != 2 && ((urs && haz(rs)) || (urt && haz(rt)));
    endfunction

    function automatic bit e_issue();
        return !rst && dv && !e_stall() && !fl && mst != 2;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit   st_e;
        bit   is_e;
        ent_t e;
        if (rst) begin
            q.delete();
            for (int k = 0; k < D; k++) q.push_back('{1'b0, 5'd0, 1'b0});
            mst    = 0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            st_e = e_stall();
            is_e = e_issue();
            e = is_e ? '{1'b1, dst, rw} : '{1'b0, 5'd0, 1'b0};
            if (st_e && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (fl && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
            q.push_front(e);
            void'(q.pop_back());
            if (fl) begin
                for (int k = 0; k < FD; k++) q[k] = '{1'b0, 5'd0, 1'b0};
            end
            mst = fl ? 2 : ((mst == 2) ? 0 : (st_e ? 1 : 0));
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("stall", 32'(stall), 32'(e_stall()));
            chk("issue", 32'(issue), 32'(e_issue()));
            chk("bubble", 32'(bubble), 32'(!e_issue()));
            chk("state", 32'(state), 32'(mst));
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", scnt, 32'(m_scnt));
            chk("flush_cnt", fcnt, 32'(m_fcnt));
`endif
        end
    end

    task automatic cyc(input logic d, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub,
                       input logic [4:0] w, input logic wr, input logic f);
        @(posedge clk);
        #1;
        dv  = d;
        rs  = a;
        urs = ua;
        rt  = b;
        urt = ub;
        dst = w;
        rw  = wr;
        fl  = f;
        #3;
        s_stall = stall;
        s_issue = issue;
        s_state = state;
    endtask

    initial begin
        int n;
        int g;
        @(posedge clk);
        go = 1'b1;

        // held in reset with a valid decode
        cyc(1, 1, 1, 2, 1, 3, 1, 0);
        chk("rst_issue", 32'(s_issue), 32'd0);
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd1);
        chk("rst_state", 32'(s_state), 32'd0);
        rst = 1'b0;

        // add $3, then a reader of $3
        cyc(1, 1, 1, 2, 1, 3, 1, 0);
        chk("s1_writer_issue", 32'(s_issue), 32'd1);
        n = 0;
        g = 0;
        do begin
            cyc(1, 3, 1, 4, 0, 9, 1, 0);
            if (s_stall) n++;
            g++;
        end while (!s_issue && g < 10);
        chk("s1_stall_cycles", 32'(n), 32'((WB != 0) ? D - 1 : D));
        chk("s1_reader_issue", 32'(s_issue), 32'd1);

        // stall on $5 coinciding with a flush
        cyc(1, 0, 0, 0, 0, 5, 1, 0);
        chk("s3_writer_issue", 32'(s_issue), 32'd1);
        cyc(1, 5, 1, 0, 0, 6, 1, 1);
        chk("s3_stall", 32'(s_stall), 32'd1);
        chk("s3_issue", 32'(s_issue), 32'd0);
        cyc(1, 5, 1, 0, 0, 6, 1, 0);
        chk("s3_state_flush", 32'(s_state), 32'd2);
        chk("s3_flush_stall", 32'(s_stall), 32'd0);
        chk("s3_flush_issue", 32'(s_issue), 32'd0);
        cyc(1, 5, 1, 0, 0, 6, 1, 0);
        chk("s3_state_run", 32'(s_state), 32'd0);
        chk("s3_reissue", 32'(s_issue), 32'd1);
`ifdef HAZARD_STATS_EN
        chk("s6_stall_cnt", scnt, 32'(((WB != 0) ? D - 1 : D) + 1));
        chk("s6_flush_cnt", fcnt, 32'd1);
`endif

        // $0 writer then $0 reader
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        chk("s2_w0_issue", 32'(s_issue), 32'd1);
        cyc(1, 0, 1, 0, 1, 4, 1, 0);
        chk("s2_r0_stall", 32'(s_stall), 32'd0);
        chk("s2_r0_issue", 32'(s_issue), 32'd1);

        // independent stream
        n = 0;
        g = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 5'(9 + i % 8), 1, 5'(17 + i % 8), 1, 5'(1 + i % 8), 1, 0);
            if (s_stall) n++;
            if (s_issue) g++;
        end
        chk("s4_stalls", 32'(n), 32'd0);
        chk("s4_issues", 32'(g), 32'd20);

        // random traffic over a small register set
        for (int i = 0; i < 400; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0));
        end

        // reset in the middle of a stall
        cyc(1, 0, 0, 0, 0, 7, 1, 0);
        cyc(1, 7, 1, 0, 0, 8, 1, 0);
        cyc(1, 7, 1, 0, 0, 8, 1, 0);
        chk("s5_pre_stall", 32'(s_stall), 32'd1);
        chk("s5_pre_state", 32'(s_state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_rst_stall", 32'(stall), 32'd0);
        chk("s5_rst_bubble", 32'(bubble), 32'd1);
        chk("s5_rst_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 7, 1, 0, 0, 8, 1, 0);
        chk("s5_post_stall", 32'(s_stall), 32'd0);
        chk("s5_post_issue", 32'(s_issue), 32'd1);

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
